// File: rtl/switch_debounce_pkg.sv
// Shared constants for the switch conditioner, the 3-input logic function
// it feeds, and their benches.
//   DEF_WIDTH          default number of switches (matches the switches bus)
//   DEF_STABLE_CYCLES  default consecutive disagreeing cycles before a flip
//   DEF_CNT_W          default stability counter width
//   SW_A/SW_B/SW_C     bit positions of the switches on the bus
package switch_debounce_pkg;

  localparam int unsigned DEF_WIDTH         = 3;
  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_CNT_W         = 8;

  localparam int unsigned SW_A = 2;
  localparam int unsigned SW_B = 1;
  localparam int unsigned SW_C = 0;

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-switch conditioner: two-flop synchroniser, stability counter and
// one-cycle change pulse.
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   raw_i      asynchronous bouncy switch level
//   level_o    debounced level (registered)
//   pulse_o    high for the one cycle in which level_o takes a new value
//   pulse_d_o  next-state of pulse_o, for coincident registered reductions
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_d_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s2_q == level_q) begin
      // Any return to agreement discards the partial count.
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s2_q;
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o   = level_q;
  assign pulse_o   = pulse_q;
  assign pulse_d_o = pulse_d;

endmodule

// File: rtl/switch_debounce.sv
// Input conditioner for the board switches feeding the 3-input logic
// function: synchronises and debounces each switch, and flags clean changes.
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   sw_raw       asynchronous bouncy switch levels (bit 2 = A, bit 0 = C)
//   switches     debounced levels, to the logic function's switches input
//   changed      per-bit one-cycle pulse when switches[i] takes a new value
//   any_changed  registered OR of changed, coincident with it
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] changed,
  output logic             any_changed
);

  logic [WIDTH-1:0] changed_d;
  logic             any_changed_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .raw_i     (sw_raw[g]),
      .level_o   (switches[g]),
      .pulse_o   (changed[g]),
      .pulse_d_o (changed_d[g])
    );
  end

  // Reducing the per-bit next-state keeps any_changed registered yet in the
  // same cycle as changed, rather than one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_changed_q <= 1'b0;
    end else begin
      any_changed_q <= |changed_d;
    end
  end

  assign any_changed = any_changed_q;

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;
  import switch_debounce_pkg::*;

  localparam int unsigned W  = DEF_WIDTH;
  localparam int unsigned SC = DEF_STABLE_CYCLES;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] switches;
  logic [W-1:0] changed;
  logic         any_changed;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: the level a switch is seen at is the raw level captured
  // two edges earlier (zero just after reset); the output accepts a new level
  // once the last SC seen samples all disagree with it.
  logic [W-1:0] m_out   = '0;
  logic [W-1:0] m_pulse = '0;
  logic [W-1:0] hist_q[$];
  logic [W-1:0] seen_q[$];

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH         (W),
    .STABLE_CYCLES (SC),
    .CNT_W         (DEF_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_raw      (sw_raw),
    .switches    (switches),
    .changed     (changed),
    .any_changed (any_changed)
  );

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] raw, input logic r);
    logic [W-1:0] seen;
    int unsigned  n;
    logic         all_diff;
    m_pulse = '0;
    if (r) begin
      hist_q.delete();
      seen_q.delete();
      m_out = '0;
    end else begin
      n    = hist_q.size();
      seen = (n >= 2) ? hist_q[n-2] : '0;
      seen_q.push_back(seen);
      hist_q.push_back(raw);
      if (hist_q.size() > 2) void'(hist_q.pop_front());
      if (seen_q.size() > SC) void'(seen_q.pop_front());
      if (seen_q.size() == SC) begin
        for (int unsigned b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int unsigned j = 0; j < SC; j++)
            if (seen_q[j][b] == m_out[b]) all_diff = 1'b0;
          m_pulse[b] = all_diff;
        end
      end
      m_out = m_out ^ m_pulse;
    end
  endtask

  task automatic step(input logic [W-1:0] raw, input logic r);
    sw_raw = raw;
    rst    = r;
    @(posedge clk);
    #1;
    model_edge(raw, r);
    check_vec("switches", switches, m_out);
    check_vec("changed", changed, m_pulse);
    check_vec("any_changed", W'(any_changed), W'(|m_pulse));
  endtask

  initial begin
    int unsigned pulses;
    logic [W-1:0] v;
    int unsigned  hold;
    logic         r;

    sw_raw = '0;
    rst    = 1'b1;

    // Reset held with all switches high, then released.
    repeat (3) step(3'b111, 1'b1);
    repeat (8) step(3'b111, 1'b0);
    repeat (10) step(3'b000, 1'b0);

    // Clean step on B.
    repeat (12) step(3'b010, 1'b0);
    repeat (10) step(3'b000, 1'b0);

    // Short glitch on C must be rejected.
    repeat (3) step(3'b001, 1'b0);
    repeat (20) step(3'b000, 1'b0);
    check_vec("glitch_level", switches, 3'b000);

    // Bounce on A then settle high.
    step(3'b100, 1'b0); step(3'b000, 1'b0); step(3'b100, 1'b0);
    step(3'b000, 1'b0);
    repeat (12) step(3'b100, 1'b0);
    repeat (10) step(3'b000, 1'b0);

    // Two bits together.
    repeat (10) step(3'b101, 1'b0);
    repeat (10) step(3'b000, 1'b0);

    // Reset on the fourth edge of a pending change.
    repeat (3) step(3'b111, 1'b0);
    step(3'b111, 1'b1);
    repeat (8) step(3'b111, 1'b0);
    check_vec("post_reset_level", switches, 3'b111);
    repeat (10) step(3'b000, 1'b0);

    // Sweep every code, one clean change per step.
    for (int unsigned c = 0; c < 8; c++) begin
      pulses = 0;
      for (int unsigned k = 0; k < 10; k++) begin
        step(W'(c), 1'b0);
        if (any_changed === 1'b1) pulses++;
      end
      check_vec("sweep_code", switches, W'(c));
      check_vec("sweep_pulses", W'(pulses), (c == 0) ? W'(0) : W'(1));
    end

    // Random bouncing with occasional resets.
    for (int unsigned t = 0; t < 400; t++) begin
      v    = W'($urandom_range(0, 7));
      hold = $urandom_range(1, 7);
      r    = ($urandom_range(0, 49) == 0);
      for (int unsigned k = 0; k < hold; k++)
        step(v, r && (k == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
